square_frame_ctrl: RTL and testbench

//  Per-frame scheduler for the moving-square renderer. It detects the start of each frame from VGA

---
 rtl/square_frame_ctrl_pkg.sv | 60 ++++++
 rtl/square_frame_ctrl_vsync_edge_sync.sv | 23 ++
 rtl/square_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_square_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_frame_ctrl_pkg.sv
// Shared types and helpers for the moving-square frame controller:
// colour codes, screen defaults and the per-axis bounce step.
package square_frame_ctrl_pkg;

   localparam int unsigned H_RES_DEF   = 640;
   localparam int unsigned V_RES_DEF   = 480;
   localparam int unsigned COORD_W_DEF = 10;
   localparam int unsigned DWELL_W_DEF = 6;

   // Two guard bits so pos+speed+size never wraps.
   localparam int unsigned AXIS_W = COORD_W_DEF + 2;

   typedef logic [AXIS_W-1:0] axis_val_t;

   localparam axis_val_t AXIS_ONE = axis_val_t'(1);

   typedef enum logic [3:0] {
      COL_RED   = 4'b1000,
      COL_GREEN = 4'b0100,
      COL_BLUE  = 4'b0010,
      COL_IDLE  = 4'b0001
   } color_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   typedef struct packed {
      axis_val_t pos;
      dir_t      dir;
   } axis_t;

   function automatic axis_t axis_step(input axis_val_t pos,
                                       input axis_val_t speed,
                                       input axis_val_t size,
                                       input axis_val_t lim,
                                       input dir_t      dir);
      axis_t r;
      r.pos = pos;
      r.dir = dir;
      if (dir == DIR_POS) begin
         if (pos + speed + size > lim - AXIS_ONE) begin
            r.pos = lim - AXIS_ONE - size;
            r.dir = DIR_NEG;
         end else begin
            r.pos = pos + speed;
         end
      end else begin
         if (pos < speed) begin
            r.pos = '0;
            r.dir = DIR_POS;
         end else begin
            r.pos = pos - speed;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/square_frame_ctrl_vsync_edge_sync.sv
// Two-flop synchroniser for the raw vsync plus a falling-edge detector.
// Flops reset to the idle-high level so reset release never looks like an edge.
module vsync_edge_sync (
   input  logic clck,
   input  logic reset_n,
   input  logic vsync,
   output logic fall
);

   // [0],[1] synchroniser stages; [2] previous synchronised value
   logic [2:0] sync_q;

   always_ff @(posedge clck or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[1:0], vsync};
      end
   end

   assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/square_frame_ctrl.sv
// Per-frame attribute scheduler for the moving-square renderer: stages config
// over valid/ready and updates position, size and colour once per vsync.
module square_frame_ctrl
   import square_frame_ctrl_pkg::*;
#(
   parameter int unsigned H_RES   = H_RES_DEF,
   parameter int unsigned V_RES   = V_RES_DEF,
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned DWELL_W = DWELL_W_DEF
) (
   input  logic               clck,
   input  logic               reset_n,
   input  logic               vsync,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [COORD_W-1:0] cfg_size,
   input  logic [3:0]         cfg_speed,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_hold,
   output logic [COORD_W-1:0] sq_x,
   output logic [COORD_W-1:0] sq_y,
   output logic [COORD_W-1:0] sq_size,
   output logic [3:0]         color,
   output logic               frame_tick
);

   localparam axis_val_t          H_LIM    = axis_val_t'(H_RES);
   localparam axis_val_t          V_LIM    = axis_val_t'(V_RES);
   localparam logic [COORD_W-1:0] SIZE_MIN = COORD_W'(1);
   localparam logic [COORD_W-1:0] SIZE_MAX = COORD_W'(V_RES - 1);

   function automatic logic [COORD_W-1:0] clamp_size(input logic [COORD_W-1:0] s);
      if (s == '0)
         return SIZE_MIN;
      else if (s > SIZE_MAX)
         return SIZE_MAX;
      else
         return s;
   endfunction

   logic               tick_now;

   logic [COORD_W-1:0] x_q, x_n, y_q, y_n;
   dir_t               xdir_q, xdir_n, ydir_q, ydir_n;
   logic [COORD_W-1:0] size_q, size_n;
   logic [3:0]         speed_q, speed_n;
   logic [DWELL_W-1:0] dwell_q, dwell_n;
   logic [DWELL_W-1:0] cnt_q, cnt_n;
   color_t             color_q, color_n;
   logic               tick_q;
   logic               ready_q, ready_n;
   logic               clr_pend_q, clr_pend_n;
   logic [COORD_W-1:0] stg_size_q, stg_size_n;
   logic [3:0]         stg_speed_q, stg_speed_n;
   logic [DWELL_W-1:0] stg_dwell_q, stg_dwell_n;

   logic [COORD_W-1:0] eff_size;
   logic [3:0]         eff_speed;
   logic [DWELL_W-1:0] eff_dwell;
   axis_val_t          x_top, y_top;
   axis_t              x_nx, y_nx;
   color_t             color_adv;
   logic               color_ok;

   vsync_edge_sync u_vsync_edge_sync (
      .clck    (clck),
      .reset_n (reset_n),
      .vsync   (vsync),
      .fall    (tick_now)
   );

   always_comb begin
      x_n         = x_q;
      y_n         = y_q;
      xdir_n      = xdir_q;
      ydir_n      = ydir_q;
      size_n      = size_q;
      speed_n     = speed_q;
      dwell_n     = dwell_q;
      cnt_n       = cnt_q;
      color_n     = color_q;
      ready_n     = ready_q;
      clr_pend_n  = clr_pend_q;
      stg_size_n  = stg_size_q;
      stg_speed_n = stg_speed_q;
      stg_dwell_n = stg_dwell_q;
      eff_size    = size_q;
      eff_speed   = speed_q;
      eff_dwell   = dwell_q;
      x_top       = '0;
      y_top       = '0;
      x_nx        = '0;
      y_nx        = '0;
      color_adv   = COL_RED;
      color_ok    = 1'b1;

      // Staging is reopened one cycle after the tick that consumed it.
      if (clr_pend_q) begin
         ready_n    = 1'b1;
         clr_pend_n = 1'b0;
      end

      if (cfg_valid && ready_q) begin
         stg_size_n  = clamp_size(cfg_size);
         stg_speed_n = cfg_speed;
         stg_dwell_n = cfg_dwell;
         ready_n     = 1'b0;
      end

      if (tick_now) begin
         if (!ready_q && !clr_pend_q) begin
            eff_size   = stg_size_q;
            eff_speed  = stg_speed_q;
            eff_dwell  = stg_dwell_q;
            clr_pend_n = 1'b1;
         end
         size_n  = eff_size;
         speed_n = eff_speed;
         dwell_n = eff_dwell;

         if (cfg_hold) begin
            x_n     = '0;
            y_n     = '0;
            xdir_n  = DIR_POS;
            ydir_n  = DIR_POS;
            cnt_n   = '0;
            color_n = COL_IDLE;
         end else begin
            // Pull the origin back inside the screen for the new size, then move.
            x_top  = H_LIM - AXIS_ONE - axis_val_t'(eff_size);
            y_top  = V_LIM - AXIS_ONE - axis_val_t'(eff_size);
            x_nx   = axis_step((axis_val_t'(x_q) > x_top) ? x_top : axis_val_t'(x_q),
                               axis_val_t'(eff_speed), axis_val_t'(eff_size), H_LIM, xdir_q);
            y_nx   = axis_step((axis_val_t'(y_q) > y_top) ? y_top : axis_val_t'(y_q),
                               axis_val_t'(eff_speed), axis_val_t'(eff_size), V_LIM, ydir_q);
            x_n    = COORD_W'(x_nx.pos);
            y_n    = COORD_W'(y_nx.pos);
            xdir_n = x_nx.dir;
            ydir_n = y_nx.dir;

            case (color_q)
               COL_IDLE:  color_adv = COL_RED;
               COL_RED:   color_adv = COL_GREEN;
               COL_GREEN: color_adv = COL_BLUE;
               COL_BLUE:  color_adv = COL_RED;
               default: begin
                  color_adv = COL_RED;
                  color_ok  = 1'b0;
               end
            endcase

            if (!color_ok || cnt_q == eff_dwell) begin
               color_n = color_adv;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + DWELL_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clck or negedge reset_n) begin
      if (!reset_n) begin
         x_q         <= '0;
         y_q         <= '0;
         xdir_q      <= DIR_POS;
         ydir_q      <= DIR_POS;
         size_q      <= SIZE_MIN;
         speed_q     <= '0;
         dwell_q     <= '0;
         cnt_q       <= '0;
         color_q     <= COL_IDLE;
         tick_q      <= 1'b0;
         ready_q     <= 1'b1;
         clr_pend_q  <= 1'b0;
         stg_size_q  <= '0;
         stg_speed_q <= '0;
         stg_dwell_q <= '0;
      end else begin
         x_q         <= x_n;
         y_q         <= y_n;
         xdir_q      <= xdir_n;
         ydir_q      <= ydir_n;
         size_q      <= size_n;
         speed_q     <= speed_n;
         dwell_q     <= dwell_n;
         cnt_q       <= cnt_n;
         color_q     <= color_n;
         tick_q      <= tick_now;
         ready_q     <= ready_n;
         clr_pend_q  <= clr_pend_n;
         stg_size_q  <= stg_size_n;
         stg_speed_q <= stg_speed_n;
         stg_dwell_q <= stg_dwell_n;
      end
   end

   assign sq_x       = x_q;
   assign sq_y       = y_q;
   assign sq_size    = size_q;
   assign color      = color_q;
   assign frame_tick = tick_q;
   assign cfg_ready  = ready_q;

endmodule

// File: tb/tb_square_frame_ctrl.sv
// Self-checking bench for square_frame_ctrl: hand-derived vector table, directed
// corner sequences and randomized ticks against an integer reference model.
module tb_square_frame_ctrl;

   localparam int H = 640;
   localparam int V = 480;

   logic       clck      = 1'b0;
   logic       reset_n   = 1'b0;
   logic       vsync     = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_hold  = 1'b0;
   logic [9:0] cfg_size  = '0;
   logic [3:0] cfg_speed = '0;
   logic [5:0] cfg_dwell = '0;
   logic       cfg_ready, frame_tick;
   logic [9:0] sq_x, sq_y, sq_size;
   logic [3:0] color;

   always #5 clck = ~clck;

   square_frame_ctrl #(
      .H_RES   (640),
      .V_RES   (480),
      .COORD_W (10),
      .DWELL_W (6)
   ) dut (
      .clck       (clck),
      .reset_n    (reset_n),
      .vsync      (vsync),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_size   (cfg_size),
      .cfg_speed  (cfg_speed),
      .cfg_dwell  (cfg_dwell),
      .cfg_hold   (cfg_hold),
      .sq_x       (sq_x),
      .sq_y       (sq_y),
      .sq_size    (sq_size),
      .color      (color),
      .frame_tick (frame_tick)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: colour index 0=IDLE 1=RED 2=GREEN 3=BLUE, direction +1/-1.
   int col_code [4] = '{1, 8, 4, 2};
   int m_x, m_y, m_dx, m_dy, m_size, m_speed, m_dwell, m_cnt, m_col;
   bit m_stg;
   int s_size, s_speed, s_dwell;

   function automatic int clamp_req(input int s);
      if (s == 0) return 1;
      if (s > V - 1) return V - 1;
      return s;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
      m_size = 1; m_speed = 0; m_dwell = 0; m_cnt = 0; m_col = 0;
      m_stg = 0;
   endtask

   task automatic axis_move(inout int p, inout int d, input int lim);
      int top;
      top = lim - 1 - m_size;
      if (p > top) p = top;
      if (d > 0) begin
         if (p + m_speed > top) begin p = top; d = -1; end
         else p = p + m_speed;
      end else begin
         if (p - m_speed < 0) begin p = 0; d = 1; end
         else p = p - m_speed;
      end
   endtask

   task automatic model_tick(input bit hold);
      if (m_stg) begin
         m_size = s_size; m_speed = s_speed; m_dwell = s_dwell; m_stg = 0;
      end
      if (hold) begin
         m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_cnt = 0; m_col = 0;
      end else begin
         axis_move(m_x, m_dx, H);
         axis_move(m_y, m_dy, V);
         if (m_cnt == m_dwell) begin
            m_col = (m_col == 3 || m_col == 0) ? 1 : m_col + 1;
            m_cnt = 0;
         end else begin
            m_cnt = (m_cnt + 1) % 64;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clck);
      reset_n = 1'b0;
      vsync = 1'b1; cfg_valid = 1'b0; cfg_hold = 1'b0;
      repeat (3) @(negedge clck);
      reset_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clck);
   endtask

   task automatic send_cfg(input int size, input int speed, input int dwell);
      chk("ready_before_cfg", cfg_ready, m_stg ? 0 : 1);
      cfg_valid = 1'b1;
      cfg_size = size[9:0]; cfg_speed = speed[3:0]; cfg_dwell = dwell[5:0];
      @(negedge clck);
      cfg_valid = 1'b0;
      if (!m_stg) begin
         m_stg = 1; s_size = clamp_req(size); s_speed = speed; s_dwell = dwell;
      end
   endtask

   // One vsync pulse; optionally offers a config in the same cycle as the tick.
   task automatic run_tick(input bit hold, input bit cc_en, input int cc_size,
                           input int cc_speed, input int cc_dwell);
      int n;
      bit stg_before, accepted;
      cfg_hold = hold;
      vsync = 1'b0;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clck);
         if (frame_tick) begin n = i; break; end
         if (i == 2 && cc_en) begin
            cfg_valid = 1'b1;
            cfg_size = cc_size[9:0]; cfg_speed = cc_speed[3:0]; cfg_dwell = cc_dwell[5:0];
         end
      end
      cfg_valid = 1'b0;
      chk("tick_latency", n, 3);
      stg_before = m_stg;
      accepted = cc_en && !stg_before;
      model_tick(hold);
      if (accepted) begin
         m_stg = 1; s_size = clamp_req(cc_size); s_speed = cc_speed; s_dwell = cc_dwell;
      end
      chk("x", sq_x, m_x);
      chk("y", sq_y, m_y);
      chk("size", sq_size, m_size);
      chk("color", color, col_code[m_col]);
      chk("ready_at_tick", cfg_ready, (stg_before || accepted) ? 0 : 1);
      @(negedge clck);
      chk("tick_one_cycle", frame_tick, 0);
      chk("ready_after_tick", cfg_ready, m_stg ? 0 : 1);
      vsync = 1'b1;
      repeat (4) @(negedge clck);
   endtask

   typedef struct {
      bit cfg_en;
      int size, speed, dwell;
      bit hold;
      int ex, ey, esize, ecol;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;

      tbl[0]  = '{1,   40, 5, 0, 0,  5,  5,  40, 8};
      tbl[1]  = '{0,    0, 0, 0, 0, 10, 10,  40, 4};
      tbl[2]  = '{0,    0, 0, 0, 0, 15, 15,  40, 2};
      tbl[3]  = '{1,    0, 5, 2, 0, 20, 20,   1, 2};
      tbl[4]  = '{1, 1000, 5, 2, 0, 25,  0, 479, 2};
      tbl[5]  = '{1,   40, 5, 2, 0, 30,  0,  40, 8};
      tbl[6]  = '{0,    0, 0, 0, 0, 35,  5,  40, 8};
      tbl[7]  = '{0,    0, 0, 0, 0, 40, 10,  40, 8};
      tbl[8]  = '{0,    0, 0, 0, 0, 45, 15,  40, 4};
      tbl[9]  = '{0,    0, 0, 0, 1,  0,  0,  40, 1};
      tbl[10] = '{1,   50, 5, 2, 1,  0,  0,  50, 1};
      tbl[11] = '{0,    0, 0, 0, 0,  5,  5,  50, 1};
      tbl[12] = '{0,    0, 0, 0, 0, 10, 10,  50, 1};
      tbl[13] = '{0,    0, 0, 0, 0, 15, 15,  50, 8};

      // Reset state, no spurious tick, first tick latency
      model_reset();
      repeat (3) @(negedge clck);
      chk("rst_x", sq_x, 0);
      chk("rst_size", sq_size, 1);
      chk("rst_color", color, 1);
      chk("rst_ready", cfg_ready, 1);
      reset_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clck);
         if (frame_tick) seen++;
      end
      chk("no_tick_after_reset", seen, 0);
      chk("rel_y", sq_y, 0);
      chk("rel_tick", frame_tick, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("first_tick_color", color, 8);

      // Vector table
      do_reset();
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].cfg_en) send_cfg(tbl[i].size, tbl[i].speed, tbl[i].dwell);
         run_tick(tbl[i].hold, 0, 0, 0, 0);
         chk($sformatf("vec%0d_x", i), sq_x, tbl[i].ex);
         chk($sformatf("vec%0d_y", i), sq_y, tbl[i].ey);
         chk($sformatf("vec%0d_size", i), sq_size, tbl[i].esize);
         chk($sformatf("vec%0d_color", i), color, tbl[i].ecol);
      end
      cfg_hold = 1'b0;

      // Bounce off both x edges
      do_reset();
      send_cfg(40, 15, 0);
      repeat (39) run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_585", sq_x, 585);
      send_cfg(40, 10, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_595", sq_x, 595);
      send_cfg(40, 7, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_599", sq_x, 599);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_592", sq_x, 592);
      send_cfg(40, 15, 0);
      repeat (39) run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_7", sq_x, 7);
      send_cfg(40, 4, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_3", sq_x, 3);
      send_cfg(40, 7, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_0", sq_x, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("bounce_x_turn", sq_x, 7);

      // Reset while mid-motion with a config staged
      send_cfg(77, 3, 1);
      chk("staged_ready_low", cfg_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_x", sq_x, 0);
      chk("async_rst_y", sq_y, 0);
      chk("async_rst_size", sq_size, 1);
      chk("async_rst_color", color, 1);
      chk("async_rst_tick", frame_tick, 0);
      chk("async_rst_ready", cfg_ready, 1);
      @(negedge clck);
      @(negedge clck);
      reset_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clck);
      run_tick(0, 0, 0, 0, 0);
      chk("no_stale_size", sq_size, 1);

      // Handshake coincident with a tick
      do_reset();
      run_tick(0, 1, 100, 2, 0);
      chk("cc_size_unchanged", sq_size, 1);
      chk("cc_ready_between", cfg_ready, 0);
      run_tick(0, 0, 0, 0, 0);
      chk("cc_size_applied", sq_size, 100);
      chk("cc_ready_restored", cfg_ready, 1);

      // Randomized ticks against the model
      do_reset();
      for (int k = 0; k < 80; k++) begin
         int sz, sp, dw;
         bit hold, cc;
         sz = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(480, 1023)))
                                          : int'($urandom_range(1, 200));
         sp = $urandom_range(0, 15);
         dw = $urandom_range(0, 3);
         hold = ($urandom_range(0, 9) == 0);
         cc = ($urandom_range(0, 9) == 0);
         if (!m_stg && $urandom_range(0, 99) < 40) send_cfg(sz, sp, dw);
         run_tick(hold, cc, sz, sp, dw);
      end
      cfg_hold = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
